// File: rtl/cond_pkg.sv
// Shared types and bit positions for the condition unit.
// Optional COND_PERF_EN adds executed/squashed counters in cond_unit.
package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_e;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    localparam int unsigned FW_NZ = 1;
    localparam int unsigned FW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational evaluation of a 4-bit condition field against {N,Z,C,V}.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        cond_ex = 1'b0;
        case (cond_e'(cond))
            EQ: cond_ex = z;
            NE: cond_ex = ~z;
            CS: cond_ex = c;
            CC: cond_ex = ~c;
            MI: cond_ex = n;
            PL: cond_ex = ~n;
            VS: cond_ex = v;
            VC: cond_ex = ~v;
            HI: cond_ex = c & ~z;
            LS: cond_ex = ~c | z;
            GE: cond_ex = (n == v);
            LT: cond_ex = (n != v);
            GT: cond_ex = ~z & (n == v);
            LE: cond_ex = z | (n != v);
            AL: cond_ex = 1'b1;
            NV: cond_ex = 1'b0;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Flag register, condition gating and one-entry valid/ready output stage.
// Define COND_PERF_EN to add saturating exec_count/squash_count ports.
module cond_unit
    import cond_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    cond,
    input  logic [1:0]    flag_w,
    input  logic [3:0]    alu_flags,
    input  logic [DW-1:0] alu_result,
    input  logic          pcs,
    input  logic          reg_w,
    input  logic          mem_w,
    input  logic          no_write,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          pc_src,
    output logic          reg_write,
    output logic          mem_write,
    output logic          cond_ex,
    output logic [DW-1:0] result,
`ifdef COND_PERF_EN
    output logic [31:0]   exec_count,
    output logic [31:0]   squash_count,
`endif
    output logic [3:0]    flags
);

    logic [3:0] flag_q;
    logic       ex;
    logic       accept;

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    assign flags    = flag_q;

    cond_check u_check (
        .cond    (cond),
        .flags   (flag_q),
        .cond_ex (ex)
    );

    // Squashed instructions leave the flag register untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q <= '0;
        end else if (accept && ex) begin
            if (flag_w[FW_NZ]) begin
                flag_q[FLAG_N] <= alu_flags[FLAG_N];
                flag_q[FLAG_Z] <= alu_flags[FLAG_Z];
            end
            if (flag_w[FW_CV]) begin
                flag_q[FLAG_C] <= alu_flags[FLAG_C];
                flag_q[FLAG_V] <= alu_flags[FLAG_V];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            cond_ex   <= 1'b0;
            pc_src    <= 1'b0;
            reg_write <= 1'b0;
            mem_write <= 1'b0;
            result    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            cond_ex   <= ex;
            pc_src    <= pcs & ex;
            reg_write <= reg_w & ex & ~no_write;
            mem_write <= mem_w & ex;
            result    <= alu_result;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef COND_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exec_count   <= '0;
            squash_count <= '0;
        end else if (accept) begin
            if (ex && (exec_count != '1)) begin
                exec_count <= exec_count + 32'd1;
            end
            if (!ex && (squash_count != '1)) begin
                squash_count <= squash_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: directed instructions with hand-computed results.
module tb_cond_unit;

    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    cond;
    logic [1:0]    flag_w;
    logic [3:0]    alu_flags;
    logic [DW-1:0] alu_result;
    logic          pcs, reg_w, mem_w, no_write;
    logic          out_valid;
    logic          out_ready;
    logic          pc_src, reg_write, mem_write, cond_ex;
    logic [DW-1:0] result;
    logic [3:0]    flags;
`ifdef COND_PERF_EN
    logic [31:0]   exec_count, squash_count;
`endif

    cond_unit #(.DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .cond       (cond),
        .flag_w     (flag_w),
        .alu_flags  (alu_flags),
        .alu_result (alu_result),
        .pcs        (pcs),
        .reg_w      (reg_w),
        .mem_w      (mem_w),
        .no_write   (no_write),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .pc_src     (pc_src),
        .reg_write  (reg_write),
        .mem_write  (mem_write),
        .cond_ex    (cond_ex),
        .result     (result),
`ifdef COND_PERF_EN
        .exec_count   (exec_count),
        .squash_count (squash_count),
`endif
        .flags      (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        cx;
        logic        pc;
        logic        rw;
        logic        mw;
        logic [3:0]  fl;
        logic [31:0] res;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   pops   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare each entry as writeback takes it.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            exp_t e;
            exp_t a;
            a = '{cx: cond_ex, pc: pc_src, rw: reg_write, mw: mem_write, fl: flags, res: result};
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0h expected none", a);
            end else begin
                e = q.pop_front();
                pops++;
                chk($sformatf("entry%0d", pops), 64'(a), 64'(e));
            end
        end
    end

    task automatic wait_accept();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL accept_timeout: got no accept expected accept within 20 cycles");
        in_valid = 1'b0;
    endtask

    task automatic drive(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] af,
                         input logic [31:0] r, input logic p, input logic rw,
                         input logic mw, input logic nw, input logic cx, input logic [3:0] ef);
        q.push_back('{cx: cx, pc: p & cx, rw: rw & cx & ~nw, mw: mw & cx, fl: ef, res: r});
        cond = c; flag_w = fw; alu_flags = af; alu_result = r;
        pcs = p; reg_w = rw; mem_w = mw; no_write = nw;
        in_valid = 1'b1;
    endtask

    task automatic issue(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] af,
                         input logic [31:0] r, input logic p, input logic rw,
                         input logic mw, input logic nw, input logic cx, input logic [3:0] ef);
        drive(c, fw, af, r, p, rw, mw, nw, cx, ef);
        wait_accept();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cond = '0; flag_w = '0; alu_flags = '0; alu_result = '0;
        pcs = 1'b0; reg_w = 1'b0; mem_w = 1'b0; no_write = 1'b0;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_flags", 64'(flags), 64'h0);
        chk("rst_result", 64'(result), 64'h0);
        chk("rst_intents", 64'({cond_ex, pc_src, reg_write, mem_write}), 64'h0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        //     cond    fw     alu      result   p  rw mw nw  cx  flags after
        issue(4'hE, 2'b11, 4'b0100, 32'hA1,   0, 1, 0, 0,  1, 4'b0100); // CMP equal
        issue(4'h0, 2'b00, 4'b0000, 32'hA2,   0, 1, 0, 0,  1, 4'b0100); // EQ
        issue(4'h1, 2'b11, 4'b1000, 32'hA3,   0, 1, 1, 0,  0, 4'b0100); // NE squashed
        issue(4'hE, 2'b11, 4'b1000, 32'hA4,   0, 0, 0, 0,  1, 4'b1000); // N=1 V=0
        issue(4'hA, 2'b00, 4'b0000, 32'hA5,   1, 1, 0, 0,  0, 4'b1000); // GE
        issue(4'hB, 2'b00, 4'b0000, 32'hA6,   1, 1, 0, 0,  1, 4'b1000); // LT
        issue(4'hE, 2'b11, 4'b1001, 32'hA7,   0, 0, 0, 0,  1, 4'b1001); // N=V=1 Z=0
        issue(4'hC, 2'b00, 4'b0000, 32'hA8,   0, 0, 1, 0,  1, 4'b1001); // GT
        issue(4'hD, 2'b00, 4'b0000, 32'hA9,   0, 0, 1, 0,  0, 4'b1001); // LE
        issue(4'hF, 2'b11, 4'b0110, 32'hAA,   1, 1, 1, 0,  0, 4'b1001); // NV
        issue(4'hE, 2'b11, 4'b0000, 32'hAB,   0, 0, 0, 0,  1, 4'b0000);
        issue(4'hE, 2'b01, 4'b1111, 32'hAC,   0, 0, 0, 0,  1, 4'b0011); // C,V only
        issue(4'h2, 2'b00, 4'b0000, 32'hAD,   0, 1, 0, 1,  1, 4'b0011); // CS, no_write
        issue(4'h8, 2'b00, 4'b0000, 32'hAE,   1, 0, 0, 0,  1, 4'b0011); // HI
        issue(4'h9, 2'b00, 4'b0000, 32'hAF,   0, 1, 0, 0,  0, 4'b0011); // LS
        issue(4'h6, 2'b00, 4'b0000, 32'hB1,   0, 1, 0, 0,  1, 4'b0011); // VS
        issue(4'h7, 2'b00, 4'b0000, 32'hB2,   0, 1, 0, 0,  0, 4'b0011); // VC
        issue(4'h3, 2'b00, 4'b0000, 32'hB3,   0, 0, 1, 0,  0, 4'b0011); // CC
        issue(4'h5, 2'b00, 4'b0000, 32'hB4,   0, 0, 1, 0,  1, 4'b0011); // PL

        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        issue(4'hE, 2'b11, 4'b0100, 32'hC0,   0, 1, 0, 0,  1, 4'b0100);
        drive(4'h4, 2'b11, 4'b1111, 32'hC1,   0, 1, 0, 0,  0, 4'b0100); // MI squashed
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_result", 64'(result), 64'hC0);
            chk("stall_flags", 64'(flags), 64'b0100);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_accept();
        out_ready = 1'b0;
        @(negedge clk);
        chk("swap_out_valid", 64'(out_valid), 64'd1);
        chk("swap_result", 64'(result), 64'hC1);
`ifdef COND_PERF_EN
        chk("exec_count", 64'(exec_count), 64'd13);
        chk("squash_count", 64'(squash_count), 64'd8);
`endif
        chk("held_entries", 64'(q.size()), 64'd1);

        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_flags", 64'(flags), 64'h0);
`ifdef COND_PERF_EN
        chk("midrst_exec", 64'(exec_count), 64'd0);
        chk("midrst_squash", 64'(squash_count), 64'd0);
`endif
        q.delete();
        @(negedge clk); rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        issue(4'hE, 2'b11, 4'b1010, 32'h77,   1, 1, 1, 0,  1, 4'b1010);

        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("queue_empty", 64'(q.size()), 64'd0);
        chk("entries_seen", 64'(pops), 64'd21);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cond_unit.md
# cond_unit

Consumer side of the ALU flag interface. Holds the architectural N/Z/C/V flag register, evaluates each instruction's 4-bit condition field against it, and gates register, memory, PC and flag writes. Sits between execute and writeback as a one-entry valid/ready pipeline register, forwarding the ALU result to writeback.

## Interface
Parameters:
- DW, 32, data width of the forwarded result.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  execute-stage instruction present
- in_ready  out  1  unit can accept this cycle
- cond  in  4  condition field
- flag_w  in  2  [1]: write N,Z; [0]: write C,V
- alu_flags  in  4  {N,Z,C,V} from the ALU, same cycle as in_valid
- alu_result  in  DW  ALU result
- pcs, reg_w, mem_w, no_write  in  1 each  decoded write intents
- out_valid  in/out: out  1  writeback entry present
- out_ready  in  1  writeback accepts
- pc_src, reg_write, mem_write, cond_ex  out  1 each  gated intents, registered
- result  out  DW  registered alu_result
- flags  out  4  current flag register {N,Z,C,V}
- exec_count, squash_count  out  32 each  present only with COND_PERF_EN

## Operation
- Accept = in_valid & in_ready; in_ready = ~out_valid | out_ready.
- Conditions on the flag register (pre-update): 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C; 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V; 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 NV 0.
- On accept, CondEx = check(cond, flags). Registered: cond_ex=CondEx; pc_src=pcs&CondEx; reg_write=reg_w&CondEx&~no_write; mem_write=mem_w&CondEx; result=alu_result.
- Flag update on accept only: if CondEx&flag_w[1], N,Z <= alu_flags[3:2]; if CondEx&flag_w[0], C,V <= alu_flags[1:0]. Squashed instructions never touch flags.
- Output register: loaded on accept; out_valid cleared when out_valid&out_ready and no accept; held unchanged while out_valid&~out_ready.

## Timing
- Reset (async assert, sync-safe release): out_valid=0, all gated intents=0, result=0, flags=4'b0000, counters=0. in_ready=1 after reset.
- Latency 1 cycle from accept to out_valid; throughput 1/cycle when out_ready=1.
- Back-to-back: instruction n+1 evaluates against flags written by instruction n (register updated at n's accept edge); no stall, no bypass from alu_flags.
- Stall: out_valid=1, out_ready=0 → in_ready=0, no accept, no flag write, outputs stable.
- Simultaneous drain and accept: new entry replaces old in the same edge, out_valid stays 1.
- flag_w with squashed cond: no effect. Reset mid-stall drops the held entry.

## Configuration
- COND_PERF_EN defined: exec_count increments on each accept with CondEx=1, squash_count on each accept with CondEx=0; both saturate at 32'hFFFF_FFFF; ports exist.
- Undefined: counters and ports absent; behaviour otherwise identical.

## Structure
- Package cond_pkg: cond_e enum (EQ..NV, 4-bit), flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0, flag_w bit constants FW_NZ=1, FW_CV=0.
- Sub-module cond_check: purely combinational (cond, flags) → CondEx; top holds flag register, output register, handshake, counters.

## Test plan
- Reset then CMP-style accept alu_flags=4'b0100, flag_w=2'b11, cond=AL → flags=4'b0100 next cycle; following cond=EQ, reg_w=1 → reg_write=1, cond_ex=1.
- flags=4'b0100, cond=NE, reg_w=1, mem_w=1, flag_w=2'b11, alu_flags=4'b1000 → reg_write=0, mem_write=0, flags remain 4'b0100.
- flags N=1,V=0: GE squashed, LT executes; flags Z=0,N=V=1: GT executes, LE squashed; cond=1111 always squashed.
- Hold out_ready=0 with out_valid=1 for 3 cycles while in_valid=1 → in_ready=0, result and flags unchanged; release → accept same cycle, out_valid stays 1.
- flag_w=2'b01 with alu_flags=4'b1111 from flags 4'b0000 → flags=4'b0011 (N,Z untouched).
- COND_PERF_EN: 5 executed, 3 squashed accepts → exec_count=5, squash_count=3; assert rst_n mid-stream → both 0 and out_valid=0 immediately.
